// File: rtl/mem_arbiter.sv
// mem_arbiter: I-cache / D-cache to single memory bus arbiter with bus timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise D always wins.
module mem_arbiter #(
    parameter int unsigned TMO = 255
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] i_a,
    input  logic        i_strobe,
    output logic [31:0] i_din,
    output logic        i_ready,
    input  logic [31:0] d_a,
    input  logic [31:0] d_dout,
    input  logic        d_strobe,
    input  logic        d_rw,
    output logic [31:0] d_din,
    output logic        d_ready,
    output logic [31:0] m_a,
    output logic [31:0] m_din,
    output logic        m_strobe,
    output logic        m_rw,
    input  logic [31:0] m_dout,
    input  logic        m_ready,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'(TMO - 1);

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic        last_grant, last_grant_nx;
    logic        bus_err_nx;
    logic        both;
    logic        pick_d;
    logic        gnt_strobe;

    assign both = i_strobe & d_strobe;

`ifdef ARB_ROUND_ROBIN_EN
    // on contention the side that did not win last time gets the bus
    assign pick_d = both ? ~last_grant : d_strobe;
`else
    assign pick_d = d_strobe;
`endif

    assign i_din = m_dout;
    assign d_din = m_dout;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            last_grant <= last_grant_nx;
            bus_err    <= bus_err_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        last_grant_nx = last_grant;
        bus_err_nx    = bus_err;
        case (state)
            IDLE: begin
                if (i_strobe | d_strobe) begin
                    state_nx      = pick_d ? BUSY_D : BUSY_I;
                    cnt_nx        = '0;
                    last_grant_nx = pick_d;
                end
            end
            BUSY_I, BUSY_D: begin
                cnt_nx = cnt + 16'd1;
                // completion wins over a timeout landing in the same cycle
                if (!gnt_strobe || m_ready) begin
                    state_nx = IDLE;
                end else if (cnt == CNT_MAX) begin
                    state_nx   = IDLE;
                    bus_err_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        m_a        = '0;
        m_din      = '0;
        m_rw       = 1'b0;
        m_strobe   = 1'b0;
        gnt_strobe = 1'b0;
        i_ready    = 1'b0;
        d_ready    = 1'b0;
        case (state)
            BUSY_I: begin
                m_a        = i_a;
                m_din      = d_dout;
                gnt_strobe = i_strobe;
                m_strobe   = i_strobe;
                i_ready    = i_strobe & m_ready;
            end
            BUSY_D: begin
                m_a        = d_a;
                m_din      = d_dout;
                m_rw       = d_rw;
                gnt_strobe = d_strobe;
                m_strobe   = d_strobe;
                d_ready    = d_strobe & m_ready;
            end
            default: ;
        endcase
    end

endmodule
